// File: rtl/cdc_pkg.sv
// ============================================================================
// Module      : cdc_pkg
// Description : Shared types and constants for the req/ack CDC handshake link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdc_pkg;

    // Source-side handshake states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } hs_tx_state_e;

    // Fewest flops a level synchroniser may use and still resolve metastability
    localparam int CDC_MIN_SYNC_STAGES = 2;

    // Wait counter is one bit wider than needed so it can saturate past the
    // timeout threshold without wrapping
    function automatic int cdc_cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : Multi-flop level synchroniser for a single asynchronous bit.
//               Used for ack on the source side; reusable for req on the
//               destination side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    // Never build a chain shorter than the safe minimum
    localparam int c_STAGES = (SYNC_STAGES < CDC_MIN_SYNC_STAGES) ?
                              CDC_MIN_SYNC_STAGES : SYNC_STAGES;

    logic [c_STAGES-1:0] r_chain;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[c_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[c_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source end of a 4-phase req/ack clock-domain-crossing link.
//               Accepts a word on valid/ready, holds it on data_out while
//               req_out is raised, and completes the full req/ack return-to-
//               zero sequence before accepting the next word. Flags (but never
//               aborts on) an ack phase that stalls too long.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_a,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] data_out,
    output logic              req_out,
    input  logic              ack_in,
    output logic              tx_done,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int               c_CNT_W    = cdc_cnt_width(TIMEOUT_CYC);
    // Count value on the last permitted wait cycle of a phase
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    // Saturation value: one past the threshold so the error fires only once
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(TIMEOUT_CYC);

    hs_tx_state_e        r_state;
    hs_tx_state_e        w_state_nxt;
    logic                r_req;
    logic                w_req_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_tmo;
    logic                w_ack_s;
    logic                w_accept;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk_a),
        .rst_n   (rst_n),
        .i_async (ack_in),
        .o_sync  (w_ack_s)
    );

    // A lingering ack from the previous transfer (or after reset) must fall
    // before a new word may be taken
    assign in_ready = (r_state == IDLE) && !w_ack_s;
    assign w_accept = in_valid && in_ready;

    // Next-state, datapath and timeout decisions
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_tmo       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_data_nxt  = in_data;
                    w_req_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_ACK_LO;
                end else begin
                    w_tmo = (r_cnt == c_CNT_LAST);
                    if (r_cnt != c_CNT_SAT) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            WAIT_ACK_LO: begin
                if (!w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmo = (r_cnt == c_CNT_LAST);
                    if (r_cnt != c_CNT_SAT) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase

        // A new timeout outranks a simultaneous clear
        if (w_tmo) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State, request, data, pulse, error and counter registers
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign req_out     = r_req;
    assign data_out    = r_data;
    assign tx_done     = r_done;
    assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Self-checking bench for cdc_handshake_tx: cycle table for a
//               single transfer, directed corner sequences, and a randomised
//               destination model with an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cdc_handshake_tx;

    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int TMO    = 16;
    localparam int N_RAND = 500;

    logic              clk_a = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] data_out;
    logic              req_out;
    logic              ack_in;
    logic              tx_done;
    logic              err_timeout;
    logic              err_clr;

    cdc_handshake_tx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_a       (clk_a),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .data_out    (data_out),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .tx_done     (tx_done),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk_a = ~clk_a;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle table record: inputs applied before an edge, outputs expected after it
    typedef struct packed {
        logic        vld;
        logic [7:0]  dat;
        logic        ack;
        logic        rdy_e;
        logic        req_e;
        logic [7:0]  dout_e;
        logic        done_e;
    } vec_t;

    vec_t tbl [10];

    // Completion pulse counter and "never ready while requesting" monitor
    int   n_done = 0;
    always @(negedge clk_a) begin
        if (tx_done === 1'b1) n_done++;
        if (req_out === 1'b1) check("ready_while_req", 32'(in_ready), 32'd0);
    end

    // Destination-side model: sees req, records the word, acks after a random
    // delay with sub-cycle jitter, and returns ack to zero after req falls
    logic              dest_auto = 1'b0;
    int                d_max     = 3;
    logic [DATA_W-1:0] dq [$];

    initial begin : p_dest
        logic [DATA_W-1:0] cap;
        int                t;
        forever begin
            @(posedge clk_a); #2;
            if (dest_auto && req_out === 1'b1 && ack_in == 1'b0) begin
                cap = data_out;
                dq.push_back(cap);
                repeat ($urandom_range(d_max, 0)) @(posedge clk_a);
                #($urandom_range(6, 1));
                ack_in = 1'b1;
                t = 0;
                while (req_out === 1'b1 && t < 200) begin
                    @(posedge clk_a); #2;
                    t++;
                end
                check("dest_req_fall", 32'(req_out), 32'd0);
                check("dest_data_stable", 32'(data_out), 32'(cap));
                repeat ($urandom_range(d_max, 0)) @(posedge clk_a);
                #($urandom_range(6, 1));
                ack_in = 1'b0;
            end
        end
    end

    // Present one word and hold it until the block takes it
    task automatic send_word(input logic [DATA_W-1:0] w, input bit drop_after);
        int t;
        bit rdy;
        @(negedge clk_a);
        in_valid = 1'b1;
        in_data  = w;
        t   = 0;
        rdy = in_ready;
        while (!rdy && t < 400) begin
            @(negedge clk_a);
            rdy = in_ready;
            t++;
        end
        check("send_accept", 32'(rdy), 32'd1);
        @(posedge clk_a);
        if (drop_after) begin
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (n_done < target && t < budget) begin
            @(negedge clk_a);
            t++;
        end
    endtask

    logic [DATA_W-1:0] exp_q [$];

    initial begin
        int k;
        int gap;
        logic [DATA_W-1:0] w;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ack_in   = 1'b0;
        err_clr  = 1'b0;

        //            vld   dat    ack   rdy   req   dout   done
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[1] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[6] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};

        // Reset state
        #12;
        check("rst_req",   32'(req_out),     32'd0);
        check("rst_data",  32'(data_out),    32'd0);
        check("rst_ready", 32'(in_ready),    32'd1);
        check("rst_done",  32'(tx_done),     32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
        @(negedge clk_a);
        rst_n = 1'b1;

        // Basic transfer, cycle by cycle
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_a);
            in_valid = tbl[i].vld;
            in_data  = tbl[i].dat;
            ack_in   = tbl[i].ack;
            @(posedge clk_a); #1;
            check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy_e));
            check($sformatf("tbl%0d_req",   i), 32'(req_out),  32'(tbl[i].req_e));
            check($sformatf("tbl%0d_data",  i), 32'(data_out), 32'(tbl[i].dout_e));
            check($sformatf("tbl%0d_done",  i), 32'(tx_done),  32'(tbl[i].done_e));
        end
        in_valid = 1'b0;
        @(negedge clk_a);
        check("basic_done_count", 32'(n_done), 32'd1);

        // Back-to-back with in_valid held high
        n_done = 0;
        dq.delete();
        d_max     = 3;
        dest_auto = 1'b1;
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b1);
        wait_done(3, 300);
        repeat (20) @(negedge clk_a);
        dest_auto = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd3);
        check("b2b_dest_count", 32'(dq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_word%0d", i),
                  (i < dq.size()) ? 32'(dq[i]) : 32'hDEAD, 32'(i + 1));
        end

        // Stuck-high ack while idle blocks accepts
        @(negedge clk_a);
        ack_in = 1'b1;
        repeat (4) @(negedge clk_a);
        check("stuck_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) @(negedge clk_a);
        check("stuck_no_req",  32'(req_out),  32'd0);
        check("stuck_no_data", 32'(data_out), 32'h03);
        in_valid = 1'b0;
        ack_in   = 1'b0;
        k = 0;
        while (!in_ready && k < 10) begin
            @(negedge clk_a);
            k++;
        end
        check("stuck_release_lat", 32'((k >= SYNC) && (k <= SYNC + 1)), 32'd1);

        // Timeout with err_clr held: the set must win on the threshold cycle
        err_clr = 1'b1;
        send_word(8'h5A, 1'b1);
        repeat (15) @(posedge clk_a);
        #1;
        check("tmo_before", 32'(err_timeout), 32'd0);
        @(posedge clk_a); #1;
        check("tmo_set",       32'(err_timeout), 32'd1);
        check("tmo_req_held",  32'(req_out),     32'd1);
        check("tmo_ready",     32'(in_ready),    32'd0);
        check("tmo_data_held", 32'(data_out),    32'h5A);
        @(negedge clk_a);
        err_clr = 1'b0;
        repeat (10) @(negedge clk_a);
        check("tmo_sticky",   32'(err_timeout), 32'd1);
        check("tmo_no_abort", 32'(req_out),     32'd1);
        ack_in = 1'b1;
        k = 0;
        while (req_out && k < 20) begin
            @(negedge clk_a);
            k++;
        end
        check("tmo_req_fall", 32'(req_out), 32'd0);
        n_done = 0;
        ack_in = 1'b0;
        wait_done(1, 20);
        check("tmo_completes", 32'(n_done),      32'd1);
        check("tmo_err_kept",  32'(err_timeout), 32'd1);
        @(negedge clk_a);
        err_clr = 1'b1;
        @(posedge clk_a); #1;
        check("tmo_cleared", 32'(err_timeout), 32'd0);
        @(negedge clk_a);
        err_clr = 1'b0;
        repeat (3) @(negedge clk_a);
        check("tmo_stays_clear", 32'(err_timeout), 32'd0);

        // Asynchronous reset while waiting for ack
        send_word(8'hC3, 1'b1);
        repeat (3) @(posedge clk_a);
        @(negedge clk_a);
        #2;
        check("pre_rst_req", 32'(req_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req",   32'(req_out),  32'd0);
        check("arst_data",  32'(data_out), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clk_a);
        rst_n = 1'b1;

        // Randomised traffic against the destination model
        n_done = 0;
        dq.delete();
        exp_q.delete();
        d_max     = 20;
        dest_auto = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            w   = DATA_W'($urandom);
            gap = int'($urandom_range(3, 0));
            exp_q.push_back(w);
            send_word(w, (gap != 0) || (i == N_RAND - 1));
            repeat (gap) @(negedge clk_a);
        end
        wait_done(N_RAND, 2000);
        repeat (60) @(negedge clk_a);
        dest_auto = 1'b0;
        check("rand_done_count", 32'(n_done),     32'(N_RAND));
        check("rand_dest_count", 32'(dq.size()),  32'(N_RAND));
        for (int i = 0; i < N_RAND; i++) begin
            check($sformatf("rand_word%0d", i),
                  (i < dq.size()) ? 32'(dq[i]) : 32'hDEAD, 32'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
